stream_byte_source: RTL and testbench

//   Byte FIFO sitting directly upstream of the sample stream sink; feeds its

---
 rtl/stream_byte_source.sv | 116 +++++++++++
 tb/tb_stream_byte_source.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_byte_source.sv
// First-word-fall-through byte FIFO feeding a valid/ready stream sink; counts transfers, flags overflow.
// Latency: a word written into an empty FIFO is presented on the stream the cycle after the write edge.
// Backpressure: output holds valid/data until accepted; writes while full are dropped and set sticky overflow.
module stream_byte_source #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       wr_en,
   input  logic [DATA_WIDTH-1:0]      wr_data,
   output logic                       wr_full,
   output logic                       stream_valid,
   output logic [DATA_WIDTH-1:0]      stream_data,
   input  logic                       stream_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic [CNT_WIDTH-1:0]       xfer_count,
   output logic                       overflow,
   input  logic                       clear_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   state_t                  state;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic [PW-1:0]           wr_ptr;
   logic [PW-1:0]           rd_ptr;
   logic [PW-1:0]           rd_next;
   logic [PW-1:0]           level_c;
   logic                    full_c;
   logic                    wr_acc;
   logic                    xfer;
   logic [DATA_WIDTH-1:0]   head_nxt;

   // Occupancy, full flag, handshakes and the word that becomes the head after this edge.
   always_comb begin
      level_c  = wr_ptr - rd_ptr;
      full_c   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      wr_acc   = wr_en & ~full_c;
      xfer     = stream_valid & stream_ready;
      rd_next  = rd_ptr + PW'(xfer);
      // When the new head slot is the one being written this edge, the array
      // does not hold it yet, so bypass the incoming word.
      if (wr_acc && (rd_next == wr_ptr))
         head_nxt = wr_data;
      else
         head_nxt = mem[rd_next[AW-1:0]];
   end

   assign wr_full = full_c;
   assign level   = level_c;

   // Storage array; contents are don't-care after reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (wr_acc)
         mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   // Pointers, counters, overflow flag and the output-side FSM with registered valid/data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_EMPTY;
         stream_valid <= 1'b0;
         stream_data  <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         xfer_count   <= '0;
         overflow     <= 1'b0;
      end else begin
         if (wr_acc)
            wr_ptr <= wr_ptr + PW'(1);
         if (xfer) begin
            rd_ptr     <= rd_next;
            xfer_count <= xfer_count + CNT_WIDTH'(1);
         end
         // A dropped write wins over a clear in the same cycle.
         if (wr_en && full_c)
            overflow <= 1'b1;
         else if (clear_overflow)
            overflow <= 1'b0;

         case (state)
            ST_EMPTY: begin
               if (wr_acc) begin
                  state        <= ST_HOLD;
                  stream_valid <= 1'b1;
                  stream_data  <= wr_data;
               end
            end
            ST_HOLD: begin
               if (xfer) begin
                  if ((level_c == PW'(1)) && !wr_acc) begin
                     // Last word leaves with nothing behind it; data holds its old value.
                     state        <= ST_EMPTY;
                     stream_valid <= 1'b0;
                  end else begin
                     stream_data  <= head_nxt;
                  end
               end
            end
            default: begin
               state        <= ST_EMPTY;
               stream_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stream_byte_source.sv
// Directed bench for stream_byte_source: hand-computed expectations per scenario.
// Inputs are driven 1 time unit after the rising edge; outputs are checked in the same window.
// Summary line reports vectors applied and miscompares.
module tb_stream_byte_source;

   logic        clk;
   logic        reset_n;
   logic        wr_en;
   logic [7:0]  wr_data;
   logic        wr_full;
   logic        stream_valid;
   logic [7:0]  stream_data;
   logic        stream_ready;
   logic [3:0]  level;
   logic [15:0] xfer_count;
   logic        overflow;
   logic        clear_overflow;

   int n_vec;
   int n_err;

   stream_byte_source #(
      .DATA_WIDTH(8),
      .DEPTH(8),
      .CNT_WIDTH(16)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .wr_en(wr_en),
      .wr_data(wr_data),
      .wr_full(wr_full),
      .stream_valid(stream_valid),
      .stream_data(stream_data),
      .stream_ready(stream_ready),
      .level(level),
      .xfer_count(xfer_count),
      .overflow(overflow),
      .clear_overflow(clear_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   initial begin
      n_vec          = 0;
      n_err          = 0;
      reset_n        = 1'b0;
      wr_en          = 1'b0;
      wr_data        = 8'h00;
      stream_ready   = 1'b0;
      clear_overflow = 1'b0;
      do_reset();

      // 1: reset state, single word pass-through
      chk("rst_valid", stream_valid, 0);
      chk("rst_data", stream_data, 0);
      chk("rst_level", level, 0);
      chk("rst_full", wr_full, 0);
      chk("rst_cnt", xfer_count, 0);
      chk("rst_ovf", overflow, 0);
      wr_en = 1'b1; wr_data = 8'hA5; stream_ready = 1'b1;
      step();
      wr_en = 1'b0;
      chk("t1_valid", stream_valid, 1);
      chk("t1_data", stream_data, 8'hA5);
      chk("t1_level", level, 1);
      step();
      chk("t1_cnt", xfer_count, 1);
      chk("t1_level0", level, 0);
      chk("t1_valid0", stream_valid, 0);

      // 2: fill to full with sink stalled, then overflow
      do_reset();
      stream_ready = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         wr_en = 1'b1; wr_data = 8'(i);
         step();
      end
      chk("t2_full", wr_full, 1);
      chk("t2_level", level, 8);
      chk("t2_data", stream_data, 8'h01);
      wr_data = 8'h09;
      step();
      wr_en = 1'b0;
      chk("t2_ovf", overflow, 1);
      chk("t2_level9", level, 8);
      chk("t2_data9", stream_data, 8'h01);

      // 3: drain back-to-back
      stream_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("t3_valid", stream_valid, 1);
         chk("t3_data", stream_data, 32'(i + 1));
         step();
         if (i == 0) chk("t3_full_drop", wr_full, 0);
      end
      chk("t3_empty", stream_valid, 0);
      chk("t3_cnt", xfer_count, 8);
      clear_overflow = 1'b1;
      step();
      clear_overflow = 1'b0;
      chk("t3_ovf_clr", overflow, 0);

      // 4: streaming write+ready, pointers wrap
      wr_en = 1'b1; stream_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         wr_data = 8'(8'h10 + i);
         step();
         chk("t4_valid", stream_valid, 1);
         chk("t4_data", stream_data, 32'(8'h10 + i));
         chk("t4_level", level, 1);
      end
      wr_en = 1'b0;
      step();
      chk("t4_valid0", stream_valid, 0);
      chk("t4_level0", level, 0);
      chk("t4_ovf", overflow, 0);
      chk("t4_cnt", xfer_count, 28);

      // 5: async reset with 5 stored words
      stream_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h40 + i);
         step();
      end
      wr_en = 1'b0;
      chk("t5_level5", level, 5);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t5_async_valid", stream_valid, 0);
      chk("t5_async_data", stream_data, 0);
      chk("t5_async_level", level, 0);
      chk("t5_async_cnt", xfer_count, 0);
      step();
      reset_n = 1'b1;
      step();
      chk("t5_rel_valid", stream_valid, 0);
      wr_en = 1'b1; wr_data = 8'h77;
      step();
      wr_en = 1'b0;
      chk("t5_valid", stream_valid, 1);
      chk("t5_data", stream_data, 8'h77);
      chk("t5_level", level, 1);
      step();
      chk("t5_hold_data", stream_data, 8'h77);
      stream_ready = 1'b1;
      step();
      chk("t5_alone", stream_valid, 0);
      chk("t5_cnt", xfer_count, 1);

      // 6: counter wrap, then overflow set beats clear
      wr_en = 1'b1; wr_data = 8'h5A; stream_ready = 1'b1;
      step();
      for (int k = 0; k < 65534; k++) step();
      chk("t6_cnt_max", xfer_count, 16'hFFFF);
      step();
      chk("t6_cnt_wrap", xfer_count, 0);
      wr_en = 1'b0;
      step();
      chk("t6_cnt_one", xfer_count, 1);
      stream_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; wr_data = 8'(i);
         step();
      end
      clear_overflow = 1'b1;
      step();
      wr_en = 1'b0;
      chk("t6_set_wins", overflow, 1);
      step();
      clear_overflow = 1'b0;
      chk("t6_clear", overflow, 0);
      chk("t6_level", level, 8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
